ysyx_25030085_ifu: RTL and testbench

//  Instruction fetch unit: owns the fetch PC, issues word reads to instruction memory over a

---
 rtl/ysyx_25030085_defs.sv | 12 +
 rtl/ysyx_25030085_ifu_fifo.sv | 46 ++++
 rtl/ysyx_25030085_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_25030085_ifu.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030085_defs.sv
// Shared constants and types for the instruction fetch unit.
package ysyx_25030085_defs;
   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/ysyx_25030085_ifu_fifo.sv
// Small synchronous FIFO holding returned fetch words; flush wins over push.
module ysyx_25030085_ifu_fifo
   import ysyx_25030085_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             din,
   output fetch_entry_t             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + AW'(push);
         rptr  <= rptr + AW'(pop);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wptr] <= din;
   end

   assign dout = mem[rptr];
endmodule

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: PC, credit-based request issue, redirect/drop tracking, output buffer.
module ysyx_25030085_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_err
);
   import ysyx_25030085_defs::*;

   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   pend_addr;
   logic          pend;
   logic          stale;
   logic [CW-1:0] inflight;
   logic [CW-1:0] inflight_next;
   logic [CW-1:0] drop;
   logic [CW-1:0] occ;
   logic [CW:0]   used;
   logic [31:0]   tag_pc [DEPTH];
   logic [AW-1:0] tag_wp;
   logic [AW-1:0] tag_rp;
   logic [31:0]   redirect_aligned;
   logic          accept;
   logic          rsp;
   logic          drop_dec;
   logic          keep;
   logic          pop;
   logic          stall;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   assign redirect_aligned = redirect_pc & ~32'h3;
   assign used             = {1'b0, inflight} + {1'b0, occ};
   // Credits come from registered counts only, so a pop this cycle frees nothing yet.
   assign imem_req_valid   = !rst && (pend || (used < DEPTH_L));
   assign imem_req_addr    = pend ? pend_addr : fetch_pc;
   assign accept           = imem_req_valid && imem_req_ready;
   assign stall            = imem_req_valid && !imem_req_ready;
   assign rsp              = imem_rsp_valid && (inflight != '0);
   assign drop_dec         = rsp && (drop != '0);
   assign keep             = rsp && !redirect_valid && (drop == '0);
   assign inflight_next    = inflight + CW'(accept) - CW'(rsp);
   assign pop              = inst_valid && inst_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         pend     <= 1'b0;
         stale    <= 1'b0;
         inflight <= '0;
         drop     <= '0;
         tag_wp   <= '0;
         tag_rp   <= '0;
      end else begin
         inflight <= inflight_next;
         pend     <= stall;
         // A request held across a redirect must still be issued, but its word is discarded.
         stale    <= stall && (redirect_valid || stale);
         if (redirect_valid)
            drop <= inflight_next;
         else
            drop <= drop - CW'(drop_dec) + CW'(accept && stale);
         if (redirect_valid)
            fetch_pc <= redirect_aligned;
         else if (accept && !stale)
            fetch_pc <= imem_req_addr + 32'd4;
         tag_wp <= tag_wp + AW'(accept);
         tag_rp <= tag_rp + AW'(rsp);
      end
   end

   always_ff @(posedge clk) begin
      if (!pend)
         pend_addr <= fetch_pc;
      if (accept)
         tag_pc[tag_wp] <= imem_req_addr;
   end

   assign push_entry.err  = imem_rsp_err;
   assign push_entry.pc   = tag_pc[tag_rp];
   assign push_entry.inst = imem_rsp_data;

   ysyx_25030085_ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (keep),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (push_entry),
      .dout  (head),
      .count (occ)
   );

   // Outputs are forced to zero whenever nothing is presented, including during reset.
   assign inst_valid = (occ != '0);
   assign inst       = !inst_valid ? 32'h0 : (head.err ? INST_NOP : head.inst);
   assign inst_pc    = inst_valid ? head.pc : 32'h0;
   assign inst_err   = inst_valid && head.err;
endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Scoreboard bench for the fetch unit with a simple in-order instruction memory model.
module tb_ysyx_25030085_ifu;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        imem_rsp_err = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   int          tests = 0;
   int          fails = 0;
   bit          run = 0;
   bit          rsp_en = 0;
   int          acc_count = 0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

   ysyx_25030085_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err)
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic err);
      exp_t e;
      e.pc   = pc;
      e.err  = err;
      e.inst = err ? NOP : word_of(pc);
      exp_q.push_back(e);
   endtask

   // Memory: records accepts seen before each edge, answers in order one cycle later.
   initial begin
      logic        acc;
      logic [31:0] a;
      logic [31:0] x;
      forever begin
         @(negedge clk);
         acc = imem_req_valid && imem_req_ready;
         a   = imem_req_addr;
         @(posedge clk);
         #2;
         if (rst) begin
            mem_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            imem_rsp_err   = 1'b0;
         end else begin
            if (acc) begin
               mem_q.push_back(a);
               acc_count++;
            end
            if (rsp_en && mem_q.size() > 0) begin
               x = mem_q.pop_front();
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = word_of(x);
               imem_rsp_err   = (x == err_addr);
            end else begin
               imem_rsp_valid = 1'b0;
               imem_rsp_data  = 32'h0;
               imem_rsp_err   = 1'b0;
            end
         end
      end
   end

   // Monitor: consumes only while expectations are queued, compares each handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         inst_ready = run && (exp_q.size() > 0);
         if (inst_valid && inst_ready) begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e.pc);
            check("inst", inst, e.inst);
            check("inst_err", {31'b0, inst_err}, {31'b0, e.err});
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst            = 1'b1;
      run            = 0;
      rsp_en         = 0;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      err_addr       = 32'hFFFF_FFFF;
      exp_q.delete();
      #1;
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_inst_err", {31'b0, inst_err}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      acc_count = 0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic pulse_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   initial begin
      // Streaming fetch after reset release
      do_reset();
      imem_req_ready = 1'b1;
      rsp_en = 1;
      for (int i = 0; i < 8; i++) push_exp(32'h8000_0000 + 32'(i * 4), 1'b0);
      run = 1;
      @(negedge clk);
      check("t1_first_req", {31'b0, imem_req_valid}, 32'h1);
      check("t1_first_addr", imem_req_addr, 32'h8000_0000);
      check("t1_valid_c0", {31'b0, inst_valid}, 32'h0);
      @(negedge clk);
      check("t1_addr_c1", imem_req_addr, 32'h8000_0004);
      check("t1_valid_c1", {31'b0, inst_valid}, 32'h0);
      @(negedge clk);
      check("t1_valid_c2", {31'b0, inst_valid}, 32'h1);
      check("t1_pc_c2", inst_pc, 32'h8000_0000);
      drain(100);

      // Core stalled: credits stop issue, head held stable
      do_reset();
      imem_req_ready = 1'b1;
      rsp_en = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("t2_hold_pc", inst_pc, 32'h8000_0000);
            check("t2_hold_inst", inst, word_of(32'h8000_0000));
         end
      end
      check("t2_accepts", acc_count, 2);
      check("t2_req_off", {31'b0, imem_req_valid}, 32'h0);
      for (int i = 0; i < 6; i++) push_exp(32'h8000_0000 + 32'(i * 4), 1'b0);
      run = 1;
      drain(100);

      // Memory back-pressure: request held stable, single accept
      do_reset();
      rsp_en = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_req_valid", {31'b0, imem_req_valid}, 32'h1);
         check("t3_req_addr", imem_req_addr, 32'h8000_0000);
      end
      @(posedge clk);
      #1;
      imem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      imem_req_ready = 1'b0;
      @(negedge clk);
      check("t3_one_accept", acc_count, 1);
      check("t3_next_addr", imem_req_addr, 32'h8000_0004);
      push_exp(32'h8000_0000, 1'b0);
      run = 1;
      drain(50);
      check("t3_accepts_after", acc_count, 1);

      // Redirect with two fetches in flight, then a misaligned redirect target
      do_reset();
      imem_req_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t4_inflight_accepts", acc_count, 2);
      check("t4_req_off", {31'b0, imem_req_valid}, 32'h0);
      @(posedge clk);
      #1;
      rsp_en = 1;
      pulse_redirect(32'h8000_0100);
      push_exp(32'h8000_0100, 1'b0);
      push_exp(32'h8000_0104, 1'b0);
      push_exp(32'h8000_0108, 1'b0);
      run = 1;
      drain(100);
      @(posedge clk);
      #1;
      pulse_redirect(32'h8000_0102);
      push_exp(32'h8000_0100, 1'b0);
      push_exp(32'h8000_0104, 1'b0);
      drain(100);

      // Redirect coinciding with a response and an output handshake
      do_reset();
      imem_req_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rsp_en = 1;
      @(posedge clk);
      #1;
      rsp_en = 0;
      @(negedge clk);
      check("t5_head_ready", {31'b0, inst_valid}, 32'h1);
      @(posedge clk);
      #1;
      push_exp(32'h8000_0000, 1'b0);
      run = 1;
      rsp_en = 1;
      pulse_redirect(32'h8000_0200);
      @(negedge clk);
      check("t5_no_stale", {31'b0, inst_valid}, 32'h0);
      check("t5_consumed", exp_q.size(), 0);
      push_exp(32'h8000_0200, 1'b0);
      push_exp(32'h8000_0204, 1'b0);
      drain(100);

      // Access fault on one word, then reset asserted mid-stream
      do_reset();
      err_addr = 32'h8000_0008;
      imem_req_ready = 1'b1;
      rsp_en = 1;
      push_exp(32'h8000_0000, 1'b0);
      push_exp(32'h8000_0004, 1'b0);
      push_exp(32'h8000_0008, 1'b1);
      push_exp(32'h8000_000C, 1'b0);
      push_exp(32'h8000_0010, 1'b0);
      run = 1;
      drain(100);
      run = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t6_busy_before_rst", {31'b0, inst_valid}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t6_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("t6_rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      check("t6_rst_inst", inst, 32'h0);
      check("t6_rst_inst_pc", inst_pc, 32'h0);
      check("t6_rst_inst_err", {31'b0, inst_err}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_restart_addr", imem_req_addr, 32'h8000_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
